// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the work-RAM arbiter
package bp_pkg;

  typedef enum logic [2:0] {
    CPU_OWN,
    HS_IDLE,
    HS_RD,
    HS_ACK,
    CLEAR
  } bp_state_e;

  localparam logic [7:0]  HS_OOR_DATA     = 8'hFF;
  localparam logic [15:0] HS_BASE_DEFAULT = 16'h8000;

endpackage

// File: rtl/bp_wram_clear.sv
// rtl/bp_wram_clear.sv - sequential clear address counter, used only when BP_WRAM_CLEAR_EN is defined
module bp_wram_clear #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (en) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign done = en && (addr_q == '1);

endmodule

// File: rtl/bp_wram_arbiter.sv
// rtl/bp_wram_arbiter.sv - Z80 / hiscore work-RAM arbiter; BP_WRAM_CLEAR_EN adds a post-reset RAM clear
module bp_wram_arbiter
  import bp_pkg::*;
#(
  parameter int          ADDR_W  = 11,
  parameter int          DATA_W  = 8,
  parameter int          RAM_LAT = 1,
  parameter logic [15:0] HS_BASE = HS_BASE_DEFAULT
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait,
  input  logic              paused,
  input  logic              hs_req,
  input  logic              hs_we,
  input  logic [15:0]       hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_ack,
  output logic              hs_owner,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef BP_WRAM_CLEAR_EN
  localparam bp_state_e RESET_STATE = CLEAR;
`else
  localparam bp_state_e RESET_STATE = CPU_OWN;
`endif

  bp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] hs_addr_q, hs_addr_d;
  logic [DATA_W-1:0] hs_wdata_q, hs_wdata_d;
  logic [DATA_W-1:0] hs_data_out_q, hs_data_out_d;
  logic              hs_wr_q, hs_wr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [15:0]       hs_offset;
  logic              hs_in_range;

  // Unsigned 16-bit subtraction: addresses below the base wrap high and fall out of range.
  assign hs_offset   = hs_address - HS_BASE;
  assign hs_in_range = ({16'b0, hs_offset} < (32'd1 << ADDR_W));

`ifdef BP_WRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;

  bp_wram_clear #(.ADDR_W(ADDR_W)) u_clear (
    .clk   (clk_49m),
    .reset (reset),
    .en    (state_q == CLEAR),
    .addr  (clr_addr),
    .done  (clr_done)
  );
`endif

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      hs_addr_q     <= '0;
      hs_wdata_q    <= '0;
      hs_data_out_q <= '0;
      hs_wr_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hs_addr_q     <= hs_addr_d;
      hs_wdata_q    <= hs_wdata_d;
      hs_data_out_q <= hs_data_out_d;
      hs_wr_q       <= hs_wr_d;
      cnt_q         <= cnt_d;
    end
  end

  // HS_RD doubles as the single write cycle (counter 0) so writes ack one clock after the RAM strobe.
  always_comb begin
    state_d       = state_q;
    hs_addr_d     = hs_addr_q;
    hs_wdata_d    = hs_wdata_q;
    hs_data_out_d = hs_data_out_q;
    hs_wr_d       = hs_wr_q;
    cnt_d         = cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (paused && !cpu_sel) state_d = HS_IDLE;
      end
      HS_IDLE: begin
        if (!paused) begin
          state_d = CPU_OWN;
        end else if (hs_req) begin
          hs_addr_d  = hs_offset[ADDR_W-1:0];
          hs_wdata_d = hs_data_in;
          hs_wr_d    = hs_we && hs_in_range;
          if (!hs_in_range) begin
            hs_data_out_d = DATA_W'(HS_OOR_DATA);
            state_d       = HS_ACK;
          end else begin
            cnt_d   = hs_we ? 2'd0 : 2'(RAM_LAT);
            state_d = HS_RD;
          end
        end
      end
      HS_RD: begin
        if (cnt_q == 2'd0) begin
          if (!hs_wr_q) hs_data_out_d = ram_dout;
          state_d = HS_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HS_ACK: begin
        state_d = paused ? HS_IDLE : CPU_OWN;
      end
`ifdef BP_WRAM_CLEAR_EN
      CLEAR: begin
        if (clr_done) state_d = CPU_OWN;
      end
`endif
      default: state_d = CPU_OWN;
    endcase
  end

  always_comb begin
    ram_addr = hs_addr_q;
    ram_we   = (state_q == HS_RD) && hs_wr_q;
    ram_din  = hs_wdata_q;
    if (state_q == CPU_OWN) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we && cpu_sel;
      ram_din  = cpu_din;
    end
`ifdef BP_WRAM_CLEAR_EN
    if (state_q == CLEAR) begin
      ram_addr = clr_addr;
      ram_we   = 1'b1;
      ram_din  = '0;
    end
    cpu_wait = (state_q == CLEAR);
`else
    cpu_wait = 1'b0;
`endif
    if (reset) ram_we = 1'b0;
    hs_ack      = (state_q == HS_ACK);
    hs_owner    = (state_q != CPU_OWN);
    hs_data_out = hs_data_out_q;
    cpu_dout    = ram_dout;
  end

endmodule

// File: tb/tb_bp_wram_arbiter.sv
// tb/tb_bp_wram_arbiter.sv - directed plus randomized bench for bp_wram_arbiter with a behavioural RAM
module tb_bp_wram_arbiter;

  localparam int RAM_LAT = 1;

  logic        clk;
  logic        reset;
  logic        cpu_sel, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_wait;
  logic        paused;
  logic        hs_req, hs_we;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in, hs_data_out;
  logic        hs_ack, hs_owner;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0]  mem     [2048];
  logic [7:0]  ref_mem [2048];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          ack_cnt = 0;
  logic [10:0] last_we_addr;
  logic [7:0]  last_we_data;
  bit          do_preload = 0;

  bp_wram_arbiter #(.RAM_LAT(RAM_LAT)) dut (
    .clk_49m     (clk),
    .reset       (reset),
    .cpu_sel     (cpu_sel),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_wait    (cpu_wait),
    .paused      (paused),
    .hs_req      (hs_req),
    .hs_we       (hs_we),
    .hs_address  (hs_address),
    .hs_data_in  (hs_data_in),
    .hs_data_out (hs_data_out),
    .hs_ack      (hs_ack),
    .hs_owner    (hs_owner),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] preload_val(input int i);
    return 8'(i * 37) | 8'h01;
  endfunction

  // Work RAM with one clock of read latency, plus write/ack monitors.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt++;
      last_we_addr = ram_addr;
      last_we_data = ram_din;
    end
    ram_dout <= mem[ram_addr];
    if (hs_ack) ack_cnt++;
    if (do_preload) for (int i = 0; i < 2048; i++) mem[i] <= preload_val(i);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit preload);
    int n, nz;
    reset = 1'b1; do_preload = preload;
    hs_req = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    do_preload = 1'b0;
    check("rst_hs_ack", hs_ack, 0);
    check("rst_hs_data_out", hs_data_out, 0);
    check("rst_ram_we", ram_we, 0);
`ifdef BP_WRAM_CLEAR_EN
    check("rst_hs_owner", hs_owner, 1);
    check("rst_cpu_wait", cpu_wait, 1);
`else
    check("rst_hs_owner", hs_owner, 0);
    check("rst_cpu_wait", cpu_wait, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef BP_WRAM_CLEAR_EN
    n = 0;
    while (cpu_wait && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, 2048);
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== 8'h00) nz++;
    check("clear_nonzero_locations", nz, 0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
`endif
    check("post_rst_owner", hs_owner, 0);
    check("post_rst_cpu_wait", cpu_wait, 0);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    cpu_sel = 1'b0; cpu_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read_check(input logic [10:0] a, input string tag);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    check(tag, cpu_dout, ref_mem[a]);
    cpu_sel = 1'b0;
  endtask

  task automatic set_paused(input bit p);
    int n;
    paused = p;
    n = 0;
    while (hs_owner !== p && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(p ? "owner_after_pause" : "owner_after_unpause", hs_owner, p);
  endtask

  // Reference: offset range, latency and data derived from the access rules, memory from ref_mem.
  task automatic hs_op(input logic we, input logic [15:0] a, input logic [7:0] d, input string tag);
    logic [15:0] off;
    bit          inr;
    int          lat, w0;
    logic [7:0]  rd;
    off = a - 16'h8000;
    inr = (off < 16'd2048);
    w0  = we_cnt;
    hs_we = we; hs_address = a; hs_data_in = d; hs_req = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!hs_ack && lat < 20);
    rd = hs_data_out;
    hs_req = 1'b0;
    @(negedge clk);
    check({tag, "_latency"}, lat, !inr ? 1 : (we ? 2 : RAM_LAT + 2));
    check({tag, "_ram_we_cycles"}, we_cnt - w0, (inr && we) ? 1 : 0);
    if (!inr) begin
      check({tag, "_oor_data"}, rd, 8'hFF);
    end else if (!we) begin
      check({tag, "_rd_data"}, rd, ref_mem[off[10:0]]);
    end else begin
      check({tag, "_wr_addr"}, last_we_addr, off[10:0]);
      check({tag, "_wr_data"}, last_we_data, d);
      ref_mem[off[10:0]] = d;
    end
  endtask

  initial begin
    int          n, a0, w0;
    logic [15:0] ra;
    logic [10:0] ca;
    logic [7:0]  cd;
    reset = 1'b1; paused = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; hs_req = 1'b0; hs_we = 1'b0;
    hs_address = '0; hs_data_in = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = preload_val(i);
    @(negedge clk);
    do_reset(1'b1);

    // CPU write with a concurrent hiscore request: the request must wait for pause.
    hs_req = 1'b1; hs_we = 1'b0; hs_address = 16'h8010;
    a0 = ack_cnt;
    cpu_write(11'h010, 8'h5A);
    repeat (5) @(negedge clk);
    check("pending_req_no_ack", ack_cnt - a0, 0);
    check("pending_req_owner", hs_owner, 0);
    paused = 1'b1;
    n = 0;
    while (!hs_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pending_ack_seen", hs_ack, 1);
    check("pending_rd_data", hs_data_out, 8'h5A);
    check("pending_owner", hs_owner, 1);
    hs_req = 1'b0;
    @(negedge clk);

    hs_op(1'b0, 16'h8010, 8'h00, "rd_8010");
    hs_op(1'b1, 16'h87FF, 8'hC3, "wr_87ff");
    hs_op(1'b0, 16'h8800, 8'h00, "rd_8800");
    hs_op(1'b0, 16'h7FFF, 8'h00, "rd_7fff");
    hs_op(1'b1, 16'h7FFF, 8'h11, "wr_7fff");
    hs_op(1'b1, 16'h0000, 8'h22, "wr_0000");
    hs_op(1'b0, 16'h8000, 8'h00, "rd_8000");
    set_paused(1'b0);
    cpu_read_check(11'h7FF, "cpu_rd_7ff");

    // Pause drops while a read is in flight: ack still comes, then the CPU owns the RAM.
    set_paused(1'b1);
    hs_req = 1'b1; hs_we = 1'b0; hs_address = 16'h8010;
    @(posedge clk);
    @(negedge clk);
    paused = 1'b0;
    n = 0;
    while (!hs_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("unpause_ack_seen", hs_ack, 1);
    check("unpause_rd_data", hs_data_out, 8'h5A);
    hs_req = 1'b0;
    @(negedge clk);
    check("unpause_owner_released", hs_owner, 0);

    // Reset during a read: no ack, no write.
    set_paused(1'b1);
    a0 = ack_cnt; w0 = we_cnt;
    hs_req = 1'b1; hs_we = 1'b0; hs_address = 16'h8020;
    @(posedge clk);
    @(negedge clk);
    do_reset(1'b0);
    check("midop_reset_no_ack", ack_cnt - a0, 0);
    check("midop_reset_no_write", we_cnt - w0, 0);

    // Randomized traffic against the reference model.
    set_paused(1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_paused(1'b0);
        ca = 11'($urandom_range(0, 2047));
        cd = 8'($urandom);
        cpu_write(ca, cd);
        cpu_read_check(11'($urandom_range(0, 2047)), "rand_cpu_rd");
        set_paused(1'b1);
      end
      case ($urandom_range(0, 3))
        0, 1:    ra = 16'h8000 + 16'($urandom_range(0, 2047));
        2:       ra = 16'($urandom_range(0, 16'h7FFF));
        default: ra = 16'($urandom_range(16'h8800, 16'hFFFF));
      endcase
      hs_op(1'($urandom_range(0, 1)), ra, 8'($urandom), "rand_hs");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
